// File: rtl/div_dp_issue.sv
// Issue stage for a multi-cycle double-precision divider with special-operand bypass and result queue.
// Define DIV_DP_ISSUE_BYPASS_EN to resolve NaN/Inf/zero operands locally without starting the divider.
module div_dp_issue #(
   parameter int DIV_LATENCY = 30,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_a,
   input  logic [63:0] in_b,
   output logic        div_start,
   output logic [63:0] div_a,
   output logic [63:0] div_b,
   input  logic [63:0] div_z,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_z,
   output logic [3:0]  out_flags,
   output logic        busy
);

   localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW   = PW + 1;
   localparam int CNTW = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;

   localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

   typedef enum logic [1:0] {IDLE, CLASSIFY, WAIT, PUSH} state_t;

   state_t            state;
   logic [CNTW-1:0]   cnt;
   logic              special;
   logic [63:0]       spec_z;
   logic [3:0]        spec_flags;
   logic              push_en;
   logic              pop_en;
   logic [63:0]       push_z;
   logic [3:0]        push_flags;
   logic [63:0]       mem_z [FIFO_DEPTH];
   logic [3:0]        mem_f [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;

   // Returns {nan, inf, zero}; subnormals count as zero.
   function automatic logic [2:0] classify(input logic [62:0] v);
      logic exp_max, exp_zero, man_zero;
      exp_max  = &v[62:52];
      exp_zero = ~|v[62:52];
      man_zero = ~|v[51:0];
      return {exp_max & ~man_zero, exp_max & man_zero, exp_zero};
   endfunction

`ifdef DIV_DP_ISSUE_BYPASS_EN
   logic [2:0] cls_a;
   logic [2:0] cls_b;
   logic       sign_z;
   assign cls_a  = classify(div_a[62:0]);
   assign cls_b  = classify(div_b[62:0]);
   assign sign_z = div_a[63] ^ div_b[63];
`endif

   // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      special    = 1'b0;
      spec_z     = '0;
      spec_flags = '0;
`ifdef DIV_DP_ISSUE_BYPASS_EN
      if (cls_a[2] | cls_b[2] | (cls_a[0] & cls_b[0]) | (cls_a[1] & cls_b[1])) begin
         special    = 1'b1;
         spec_z     = QNAN;
         spec_flags = 4'b1001;
      end else if (cls_b[0] | cls_a[1]) begin
         special    = 1'b1;
         spec_z     = {sign_z, 11'h7FF, 52'h0};
         spec_flags = 4'b0101;
      end else if (cls_a[0] | cls_b[1]) begin
         special    = 1'b1;
         spec_z     = {sign_z, 63'h0};
         spec_flags = 4'b0011;
      end
`endif
   end

   always_comb begin
      push_en    = ((state == CLASSIFY) && special) || (state == PUSH);
      push_z     = (state == PUSH) ? div_z : spec_z;
      push_flags = (state == PUSH) ? {classify(div_z[62:0]), 1'b0} : spec_flags;
   end

   assign in_ready  = (state == IDLE) && (count < CW'(FIFO_DEPTH)) && !reset;
   assign div_start = (state == CLASSIFY) && !special;
   assign busy      = (state != IDLE);
   assign out_valid = (count != '0);
   assign pop_en    = out_valid && out_ready;
   assign out_z     = out_valid ? mem_z[rd_ptr] : '0;
   assign out_flags = out_valid ? mem_f[rd_ptr] : '0;

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         div_a <= '0;
         div_b <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  div_a <= in_a;
                  div_b <= in_b;
                  state <= CLASSIFY;
               end
            end
            CLASSIFY: begin
               if (special) begin
                  state <= IDLE;
               end else begin
                  cnt   <= CNTW'(DIV_LATENCY - 1);
                  state <= (DIV_LATENCY <= 1) ? PUSH : WAIT;
               end
            end
            WAIT: begin
               // The decrement that reaches zero also moves to PUSH, so PUSH lands on the div_z valid cycle.
               if (cnt <= CNTW'(1)) begin
                  cnt   <= '0;
                  state <= PUSH;
               end else begin
                  cnt <= cnt - CNTW'(1);
               end
            end
            PUSH:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + PW'(1);
         if (pop_en)  rd_ptr <= rd_ptr + PW'(1);
         case ({push_en, pop_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: queue storage is not reset; out_z/out_flags are masked to zero while the queue is empty.
   always_ff @(posedge clk) begin
      if (push_en && !reset) begin
         mem_z[wr_ptr] <= push_z;
         mem_f[wr_ptr] <= push_flags;
      end
   end

endmodule

// File: doc/div_dp_issue.md
DIV_DP_ISSUE -- requirements
Module: div_dp_issue

Interface
REQ-001 The block SHALL have parameter DIV_LATENCY, default 30, giving the cycles from the div_start pulse to the cycle in which div_z is valid.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the result queue entries (power of two, >=2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_a (input, 64) and in_b (input, 64): the IEEE-754 double dividend and divisor request channel.
REQ-006 The block SHALL have ports div_start (output, 1), div_a (output, 64), div_b (output, 64) and div_z (input, 64): the interface to the double-precision divider.
REQ-007 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_z (output, 64) and out_flags (output, 4; {nan, inf, zero, bypass}): the result channel.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-009 The FSM SHALL have four states, IDLE, CLASSIFY, WAIT and PUSH, and SHALL hold one operation in flight at most.
REQ-010 In IDLE, in_ready SHALL be 1 when the queue count is below FIFO_DEPTH, and 0 in every other state.
REQ-011 When in_valid and in_ready are both 1, the block SHALL latch in_a and in_b, drive them on div_a and div_b, and go to CLASSIFY.
REQ-012 In CLASSIFY, operands SHALL be decoded as follows: NaN is exp 2047 with mantissa non-zero; Inf is exp 2047 with mantissa zero; Zero is exp 0 (subnormals flush to zero).
REQ-013 Special results: either operand NaN, 0/0 or Inf/Inf SHALL give 64'h7FF8_0000_0000_0000.
REQ-014 Special results: x/0 with x non-zero, and Inf/finite, SHALL give Inf with sign a^b.
REQ-015 Special results: 0/finite and finite/Inf SHALL give zero with sign a^b.
REQ-016 For a special result, the block SHALL push {result, flags with bypass=1} into the queue in CLASSIFY and return to IDLE; div_start SHALL NOT pulse.
REQ-017 Otherwise, the block SHALL pulse div_start for exactly one cycle in CLASSIFY, load a counter with DIV_LATENCY-1, and go to WAIT.
REQ-018 WAIT SHALL decrement the counter each cycle and go to PUSH when it reaches 0.
REQ-019 PUSH SHALL sample div_z, push it with flags derived from its own exponent and mantissa (bypass=0), and return to IDLE.
REQ-020 div_a and div_b SHALL be held stable from CLASSIFY through PUSH.
REQ-021 The queue SHALL be a first-in first-out queue; out_z and out_flags SHALL show the head entry, and out_valid SHALL equal count != 0.
REQ-022 On out_valid and out_ready both high, the block SHALL pop the head; out_z SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 On a simultaneous push and pop, count SHALL stay unchanged and order SHALL be preserved.
REQ-024 The in_ready gating SHALL guarantee that a push never happens with count == FIFO_DEPTH.
REQ-025 Latency: for an operation accepted at cycle T, a bypass result SHALL be at the head at T+2 and a divider result at T+DIV_LATENCY+2, given an empty queue.

Reset
REQ-026 While reset=1 at a clock edge, the block SHALL set: state IDLE, queue count 0, out_valid 0, out_z 0, out_flags 0, div_start 0, div_a 0, div_b 0, busy 0 and counter 0.
REQ-027 in_ready SHALL be 0 during any cycle in which reset=1.
REQ-028 A reset during WAIT or PUSH SHALL abandon the in-flight operation with no push; the divider shares the same reset.

Configuration
REQ-029 With macro DIV_DP_ISSUE_BYPASS_EN defined, special-operand bypass SHALL operate per REQ-013 to REQ-016.
REQ-030 With DIV_DP_ISSUE_BYPASS_EN undefined, every accepted operation SHALL go to the divider, out_flags[0] SHALL always be 0, and nan, inf and zero flags SHALL still be derived from div_z.

Verification
REQ-031 The bench SHALL cover: 0x4018000000000000 / 0x4000000000000000 (6.0/2.0) -> one div_start pulse at T+1, then out_valid at T+32 with out_z equal to the divider model output 0x4008000000000000, flags 0000.
REQ-032 The bench SHALL cover: 0x3FF0000000000000 / 0x0 (bypass build) -> no div_start, out_z 0x7FF0000000000000, flags 0101, out_valid at T+2.
REQ-033 The bench SHALL cover: 0x0 / 0x0 and 0x7FF0000000000001 / 1.0 -> out_z 0x7FF8000000000000, flags 1001, for each.
REQ-034 The bench SHALL cover: out_ready held 0 while issuing 4 bypass operations -> in_ready goes 0 after the 4th; 5th held off until one pop; order preserved on drain.
REQ-035 The bench SHALL cover: reset asserted 10 cycles into WAIT -> busy 0 and out_valid 0 the next cycle, and no result is ever emitted for that operation.
REQ-036 The bench SHALL cover: a non-bypass build with 0x8000000000000000 / 0x4000000000000000 -> div_start pulses and the result is taken from div_z with bypass flag 0.
